// File: rtl/baby_nibble_accumulator.sv
// Manchester Baby accumulator sequencer: runs SUB/LDN/ADD through one external
// 4-bit ttl283 adder, least significant nibble first, chaining the carry.
module baby_nibble_accumulator #(
  parameter int WORD_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WORD_WIDTH-1:0] operand,
  output logic [3:0]            adder_a,
  output logic [3:0]            adder_b,
  output logic                  adder_c0,
  input  logic [3:0]            adder_s,
  input  logic                  adder_c4,
  output logic [WORD_WIDTH-1:0] accumulator,
  output logic                  negative,
  output logic                  carry_out,
  output logic                  busy,
  output logic                  done
);

  localparam int NIBBLES = WORD_WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] OP_LDN = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

  state_e                state;
  logic [1:0]            op_reg;
  logic [WORD_WIDTH-1:0] operand_reg;
  logic [WORD_WIDTH-1:0] a_reg;
  logic [WORD_WIDTH-1:0] result_reg;
  logic [IDX_W-1:0]      nib_idx;
  logic [CNT_W-1:0]      settle_cnt;
  logic                  carry_reg;

  logic                  capture;
  logic                  last_nib;
  logic                  is_add;
  logic [WORD_WIDTH-1:0] next_result;

  function automatic logic [3:0] nib_of(input logic [WORD_WIDTH-1:0] word, input int idx);
    return word[4*idx +: 4];
  endfunction

  assign capture  = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign last_nib = (nib_idx == IDX_W'(NIBBLES - 1));
  assign is_add   = (op_reg == OP_ADD);
  assign negative = accumulator[WORD_WIDTH-1];

  // Result word with the nibble currently being captured replaced by the adder sum,
  // so the final edge can commit the whole word in one step.
  always_comb begin
    next_result = result_reg;
    for (int i = 0; i < NIBBLES; i++) begin
      if (int'(nib_idx) == i) next_result[4*i +: 4] = adder_s;
    end
  end

  // NOTE: adder drives are registered and loaded one edge ahead of use, so the
  // ttl283 sees inputs that are glitch-free for every settle cycle of a nibble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_reg      <= '0;
      operand_reg <= '0;
      a_reg       <= '0;
      result_reg  <= '0;
      nib_idx     <= '0;
      settle_cnt  <= '0;
      carry_reg   <= 1'b0;
      accumulator <= '0;
      carry_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      adder_a     <= '0;
      adder_b     <= '0;
      adder_c0    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          adder_a  <= '0;
          adder_b  <= '0;
          adder_c0 <= 1'b0;
          state    <= IDLE;
          if (start) begin
            state       <= SETTLE;
            busy        <= 1'b1;
            op_reg      <= op;
            operand_reg <= operand;
            a_reg       <= (op == OP_LDN) ? '0 : accumulator;
            carry_reg   <= (op != OP_ADD);
            nib_idx     <= '0;
            settle_cnt  <= '0;
            adder_a     <= (op == OP_LDN) ? 4'h0 : accumulator[3:0];
            adder_b     <= (op == OP_ADD) ? operand[3:0] : ~operand[3:0];
            adder_c0    <= (op != OP_ADD);
          end
        end

        SETTLE: begin
          if (capture) begin
            settle_cnt <= '0;
            result_reg <= next_result;
            carry_reg  <= adder_c4;
            if (last_nib) begin
              accumulator <= next_result;
              carry_out   <= adder_c4;
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              adder_a     <= '0;
              adder_b     <= '0;
              adder_c0    <= 1'b0;
            end else begin
              nib_idx  <= nib_idx + 1'b1;
              adder_a  <= nib_of(a_reg, int'(nib_idx) + 1);
              adder_b  <= is_add ? nib_of(operand_reg, int'(nib_idx) + 1)
                                 : ~nib_of(operand_reg, int'(nib_idx) + 1);
              adder_c0 <= adder_c4;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baby_nibble_accumulator.sv
// Directed bench: a 32-bit/2-settle instance and an 8-bit/1-settle instance, each
// wired to a behavioural ttl283 (S/C4 = A + B + C0).
module tb_baby_nibble_accumulator;

  logic        clk;
  logic        reset;
  logic        start_req;
  logic        w8_sel;
  logic [1:0]  op_in;
  logic [31:0] operand_in;

  logic        start32, start8;
  logic [3:0]  a32, b32, s32, a8, b8, s8;
  logic        c0_32, c4_32, c0_8, c4_8;
  logic [31:0] acc32;
  logic [7:0]  acc8;
  logic        neg32, cy32, busy32, done32;
  logic        neg8, cy8, busy8, done8;

  int checks   = 0;
  int failures = 0;

  assign start32 = start_req & ~w8_sel;
  assign start8  = start_req & w8_sel;

  assign {c4_32, s32} = {1'b0, a32} + {1'b0, b32} + {4'b0, c0_32};
  assign {c4_8, s8}   = {1'b0, a8} + {1'b0, b8} + {4'b0, c0_8};

  baby_nibble_accumulator dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op_in), .operand(operand_in),
    .adder_a(a32), .adder_b(b32), .adder_c0(c0_32), .adder_s(s32), .adder_c4(c4_32),
    .accumulator(acc32), .negative(neg32), .carry_out(cy32), .busy(busy32), .done(done32)
  );

  baby_nibble_accumulator #(.WORD_WIDTH(8), .SETTLE_CYCLES(1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op_in), .operand(operand_in[7:0]),
    .adder_a(a8), .adder_b(b8), .adder_c0(c0_8), .adder_s(s8), .adder_c4(c4_8),
    .accumulator(acc8), .negative(neg8), .carry_out(cy8), .busy(busy8), .done(done8)
  );

  wire [31:0] cur_acc   = w8_sel ? {24'b0, acc8} : acc32;
  wire        cur_neg   = w8_sel ? neg8 : neg32;
  wire        cur_cy    = w8_sel ? cy8 : cy32;
  wire        cur_busy  = w8_sel ? busy8 : busy32;
  wire        cur_done  = w8_sel ? done8 : done32;
  wire [8:0]  cur_adder = w8_sel ? {a8, b8, c0_8} : {a32, b32, c0_32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation at the current cycle and follow it to its done pulse.
  // op/operand are scrambled right after acceptance; inject pulses a stray ADD start mid-op.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] val,
                     input bit inject, input logic [31:0] exp_acc, input logic exp_cy,
                     input logic exp_neg, input int exp_cycles);
    logic [31:0] old_acc;
    int n, busy_n, held_bad;
    old_acc  = cur_acc;
    n        = 0;
    busy_n   = 0;
    held_bad = 0;
    op_in      = o;
    operand_in = val;
    start_req  = 1'b1;
    tick();
    start_req  = 1'b0;
    op_in      = ~o;
    operand_in = ~val;
    while (!cur_done && n < 200) begin
      if (cur_busy) busy_n++;
      if (cur_acc !== old_acc) held_bad++;
      if (inject && n == 3) begin
        start_req  = 1'b1;
        op_in      = 2'b10;
        operand_in = 32'hDEAD_BEEF;
      end else begin
        start_req = 1'b0;
      end
      tick();
      n++;
    end
    start_req = 1'b0;
    check({tag, "_latency"}, n, exp_cycles);
    check({tag, "_busy_cycles"}, busy_n, exp_cycles);
    check({tag, "_acc_held"}, held_bad, 0);
    check({tag, "_acc"}, cur_acc, exp_acc);
    check({tag, "_carry"}, {31'b0, cur_cy}, {31'b0, exp_cy});
    check({tag, "_neg"}, {31'b0, cur_neg}, {31'b0, exp_neg});
    check({tag, "_busy_done"}, {31'b0, cur_busy}, 32'd0);
    check({tag, "_adder_zero"}, {23'b0, cur_adder}, 32'd0);
  endtask

  initial begin
    int done_seen;
    reset      = 1'b1;
    start_req  = 1'b0;
    w8_sel     = 1'b0;
    op_in      = 2'b00;
    operand_in = '0;
    tick();
    check("rst_acc", acc32, 32'h0);
    check("rst_flags", {27'b0, neg32, cy32, busy32, done32, 1'b0}, 32'h0);
    check("rst_adder", {23'b0, a32, b32, c0_32}, 32'h0);
    reset = 1'b0;
    tick();

    run("ldn5", 2'b01, 32'h0000_0005, 1'b0, 32'hFFFF_FFFB, 1'b0, 1'b1, 16);
    check("b2b_in_done", {31'b0, done32}, 32'd1);
    run("sub_fff0", 2'b00, 32'hFFFF_FFF0, 1'b0, 32'h0000_000B, 1'b1, 1'b0, 16);
    tick();
    run("sub_c_ign", 2'b00, 32'h0000_000C, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 16);
    tick();
    run("ldn_m1", 2'b01, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 16);
    run("add_7fff", 2'b10, 32'h7FFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 16);
    run("ldn_1", 2'b01, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 16);
    run("add_wrap", 2'b10, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16);
    run("ldn_0", 2'b01, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 16);

    // Abort a SUB while nibble 3 is on the adder.
    run("ldn_seed", 2'b01, 32'hEDCB_A988, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 16);
    tick();
    op_in      = 2'b00;
    operand_in = 32'h0000_0001;
    start_req  = 1'b1;
    tick();
    start_req = 1'b0;
    repeat (6) tick();
    check("abort_nib3_adder", {23'b0, a32, b32, c0_32}, {23'b0, 4'h5, 4'hF, 1'b1});
    check("abort_acc_before", acc32, 32'h1234_5678);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_acc", acc32, 32'h0);
    check("abort_busy_done", {30'b0, busy32, done32}, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done32) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    w8_sel = 1'b1;
    tick();
    run("w8_ldn1", 2'b01, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b1, 2);
    tick();
    run("w8_ldn_f0", 2'b01, 32'h0000_00F0, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 2);
    run("w8_op11", 2'b11, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b1, 1'b0, 2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
